// File: rtl/alarma_multizona.sv
// Multi-zone intrusion controller: masked active-low PIR zones, BCD PIN keypad,
// entry delay, pulsed siren and a lockout after repeated wrong PINs.
module alarma_multizona #(
  parameter int NUM_ZONAS      = 4,
  parameter int PIN_DIGITS     = 4,
  parameter int ENTRY_CYCLES   = 50000,
  parameter int SIREN_HALF     = 25000,
  parameter int MAX_FALLOS     = 3,
  parameter int LOCKOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_ZONAS-1:0]    zona_pir,
  input  logic [NUM_ZONAS-1:0]    zona_mask,
  input  logic                    armar,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [4*PIN_DIGITS-1:0] clave_correcta,
  output logic                    alerta_pin,
  output logic                    bocina_pin,
  output logic                    armado,
  output logic                    bloqueo,
  output logic [NUM_ZONAS-1:0]    zona_disparo,
  output logic [1:0]              estado
);

  localparam int EW = (ENTRY_CYCLES > 1) ? $clog2(ENTRY_CYCLES) : 1;
  localparam int SW = (SIREN_HALF > 1) ? $clog2(SIREN_HALF) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam int DW = $clog2(PIN_DIGITS + 1);
  localparam int FW = $clog2(MAX_FALLOS + 1);
  localparam int BW = 4 * PIN_DIGITS;

  typedef enum logic [1:0] {
    DESARMADO = 2'd0,
    ARMADO    = 2'd1,
    ENTRADA   = 2'd2,
    ALARMA    = 2'd3
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [NUM_ZONAS-1:0] trig_q;
  logic [NUM_ZONAS-1:0] disparo_q, disparo_d;
  logic [EW-1:0]        ent_q, ent_d;
  logic [SW-1:0]        sir_q, sir_d;
  logic                 bocina_q, bocina_d;
  logic [LW-1:0]        lock_q, lock_d;
  logic [BW-1:0]        buf_q, buf_d;
  logic [DW-1:0]        ndig_q, ndig_d;
  logic [FW-1:0]        fallos_q, fallos_d;

  logic key_en, is_digit, is_clr, is_ent, pin_ok, disarm, fail, lock_hit;

  // Digit count stops at the PIN length so extra digits are simply dropped.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] n);
    return (n == DW'(PIN_DIGITS)) ? n : n + 1'b1;
  endfunction

  assign key_en   = key_valid && (estado_q != DESARMADO) && (lock_q == '0);
  assign is_digit = (key_code <= 4'd9);
  assign is_clr   = (key_code == 4'hA);
  assign is_ent   = (key_code == 4'hB);
  assign pin_ok   = (ndig_q == DW'(PIN_DIGITS)) && (buf_q == clave_correcta);
  assign disarm   = key_en && is_ent && pin_ok;
  assign fail     = key_en && is_ent && !pin_ok;
  assign lock_hit = fail && (fallos_q == FW'(MAX_FALLOS - 1));

  always_comb begin
    estado_d  = estado_q;
    disparo_d = disparo_q;
    ent_d     = ent_q;
    sir_d     = sir_q;
    bocina_d  = bocina_q;
    lock_d    = lock_q;
    buf_d     = buf_q;
    ndig_d    = ndig_q;
    fallos_d  = fallos_q;

    if (key_en) begin
      if (is_digit) begin
        if (ndig_q != DW'(PIN_DIGITS)) buf_d = (buf_q << 4) | BW'(key_code);
        ndig_d = sat_inc(ndig_q);
      end else if (is_clr || is_ent) begin
        buf_d  = '0;
        ndig_d = '0;
      end
    end

    if (disarm)    fallos_d = '0;
    else if (fail) fallos_d = lock_hit ? '0 : fallos_q + 1'b1;

    if (lock_hit)           lock_d = LW'(LOCKOUT_CYCLES);
    else if (lock_q != '0)  lock_d = lock_q - 1'b1;

    case (estado_q)
      DESARMADO: if (armar) begin
        estado_d  = ARMADO;
        disparo_d = '0;
        fallos_d  = '0;
      end
      ARMADO:  if (|trig_q) estado_d = ENTRADA;
      ENTRADA: if (ent_q == EW'(ENTRY_CYCLES - 1)) estado_d = ALARMA;
      default: ;
    endcase

    // A correct PIN overrides every other transition; the latched zones stay put.
    if (estado_q != DESARMADO) begin
      if (lock_hit) estado_d = ALARMA;
      if (disarm) estado_d = DESARMADO;
      else        disparo_d = disparo_q | trig_q;
    end

    if (estado_d != estado_q) begin
      ent_d    = '0;
      sir_d    = '0;
      bocina_d = (estado_d == ALARMA);
    end else if (estado_q == ENTRADA) begin
      ent_d = ent_q + 1'b1;
    end else if (estado_q == ALARMA) begin
      if (sir_q == SW'(SIREN_HALF - 1)) begin
        sir_d    = '0;
        bocina_d = ~bocina_q;
      end else begin
        sir_d = sir_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q  <= DESARMADO;
      trig_q    <= '0;
      disparo_q <= '0;
      ent_q     <= '0;
      sir_q     <= '0;
      bocina_q  <= 1'b0;
      lock_q    <= '0;
      buf_q     <= '0;
      ndig_q    <= '0;
      fallos_q  <= '0;
    end else begin
      estado_q  <= estado_d;
      trig_q    <= ~zona_pir & zona_mask;
      disparo_q <= disparo_d;
      ent_q     <= ent_d;
      sir_q     <= sir_d;
      bocina_q  <= bocina_d;
      lock_q    <= lock_d;
      buf_q     <= buf_d;
      ndig_q    <= ndig_d;
      fallos_q  <= fallos_d;
    end
  end

  assign alerta_pin   = (estado_q == ALARMA);
  assign bocina_pin   = bocina_q;
  assign armado       = (estado_q != DESARMADO);
  assign bloqueo      = (lock_q != '0);
  assign zona_disparo = disparo_q;
  assign estado       = estado_q;

endmodule

// File: tb/tb_alarma_multizona.sv
// Bench for alarma_multizona: directed scenarios plus random traffic, all
// checked every cycle against a rule-level model of the controller.
module tb_alarma_multizona;
  localparam int NZ = 4, PD = 4, EC = 10, SH = 4, MF = 2, LC = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NZ-1:0] zona_pir, zona_mask;
  logic          armar, key_valid;
  logic [3:0]    key_code;
  logic [4*PD-1:0] clave_correcta;
  logic          alerta_pin, bocina_pin, armado, bloqueo;
  logic [NZ-1:0] zona_disparo;
  logic [1:0]    estado;

  alarma_multizona #(
    .NUM_ZONAS(NZ), .PIN_DIGITS(PD), .ENTRY_CYCLES(EC),
    .SIREN_HALF(SH), .MAX_FALLOS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .zona_pir(zona_pir), .zona_mask(zona_mask),
    .armar(armar), .key_valid(key_valid), .key_code(key_code),
    .clave_correcta(clave_correcta), .alerta_pin(alerta_pin),
    .bocina_pin(bocina_pin), .armado(armado), .bloqueo(bloqueo),
    .zona_disparo(zona_disparo), .estado(estado)
  );

  int n_vec = 0, n_bad = 0;

  // Model: state number, cycles spent in that state, typed digits, fails, lockout left.
  int m_st = 0, m_age = 0, m_fails = 0, m_lock = 0;
  logic [NZ-1:0] m_trig = '0, m_disp = '0;
  int m_dig[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    int nst, val;
    logic ok, key_en, dis, fail, hit;
    if (!reset) begin
      m_st = 0; m_age = 0; m_fails = 0; m_lock = 0;
      m_trig = '0; m_disp = '0; m_dig.delete();
      return;
    end
    key_en = key_valid && m_st != 0 && m_lock == 0;
    ok = 1'b0;
    if (m_dig.size() == PD) begin
      val = 0;
      foreach (m_dig[i]) val = val * 16 + m_dig[i];
      ok = (val == int'(clave_correcta));
    end
    dis  = key_en && key_code == 4'hB && ok;
    fail = key_en && key_code == 4'hB && !ok;
    hit  = fail && (m_fails + 1 == MF);
    nst = m_st;
    if (m_st == 0 && armar) begin nst = 1; m_disp = '0; m_fails = 0; end
    if (m_st == 1 && m_trig != 0) nst = 2;
    if (m_st == 2 && m_age == EC - 1) nst = 3;
    if (m_st != 0) begin
      if (hit) nst = 3;
      if (dis) nst = 0;
      else m_disp = m_disp | m_trig;
    end
    if (dis) m_fails = 0;
    else if (fail) m_fails = hit ? 0 : m_fails + 1;
    if (hit) m_lock = LC;
    else if (m_lock > 0) m_lock--;
    if (key_en) begin
      if (key_code <= 4'd9) begin
        if (m_dig.size() < PD) m_dig.push_back(int'(key_code));
      end else if (key_code == 4'hA || key_code == 4'hB) m_dig.delete();
    end
    m_age = (nst != m_st) ? 0 : m_age + 1;
    m_st = nst;
    m_trig = ~zona_pir & zona_mask;
  endtask

  task automatic compare();
    chk("estado", estado, m_st);
    chk("alerta_pin", alerta_pin, m_st == 3);
    chk("bocina_pin", bocina_pin, (m_st == 3) && ((m_age / SH) % 2 == 0));
    chk("armado", armado, m_st != 0);
    chk("bloqueo", bloqueo, m_lock > 0);
    chk("zona_disparo", zona_disparo, m_disp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1; key_code = c;
    tick();
    key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic idle_defaults();
    zona_pir = '1; zona_mask = '1; armar = 1'b0; key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); reset = 1'b1;
  endtask

  task automatic arm();
    armar = 1'b1; tick(); armar = 1'b0;
  endtask

  task automatic type_pin();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
  endtask

  logic [7:0] pat;
  int hi, guard;
  logic [3:0] pend[$];

  initial begin
    clave_correcta = 16'h1234;
    idle_defaults();
    reset = 1'b0;

    // 1: reset with toggling inputs, then reset out of ALARMA (below)
    for (int i = 0; i < 3; i++) begin
      zona_pir = ~zona_pir; armar = ~armar; key_valid = ~key_valid; key_code = 4'hB;
      tick();
    end
    chk("rst_estado", estado, 0);
    chk("rst_outputs", {alerta_pin, bocina_pin, armado, bloqueo, zona_disparo}, 0);
    idle_defaults(); reset = 1'b1;

    // 2: zone 2 -> ENTRADA after 2 cycles, ALARMA 10 later, siren pattern
    arm();
    zona_pir[2] = 1'b0;
    tick();
    chk("s2_still_armado", estado, 1);
    tick();
    chk("s2_entrada", estado, 2);
    for (int i = 0; i < EC - 1; i++) tick();
    chk("s2_entrada_last", estado, 2);
    tick();
    chk("s2_alarma", estado, 3);
    chk("s2_disparo", zona_disparo, 4'b0100);
    pat = {7'b0, bocina_pin};
    for (int i = 0; i < 7; i++) begin tick(); pat = {pat[6:0], bocina_pin}; end
    chk("s2_siren_pattern", pat, 8'b1111_0000);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("s1_reset_in_alarma", {alerta_pin, bocina_pin, armado, bloqueo, zona_disparo, estado}, 0);
    idle_defaults();

    // 3: correct PIN during ENTRADA
    arm();
    zona_pir[0] = 1'b0; tick(); tick();
    chk("s3_entrada", estado, 2);
    zona_pir = '1;
    type_pin();
    chk("s3_disarmed", estado, 0);
    chk("s3_disparo", zona_disparo, 4'b0001);
    chk("s3_alerta", alerta_pin, 0);

    // 4: masked zone 0 never triggers; zone 3 does
    zona_mask = 4'b1110; zona_pir[0] = 1'b0;
    arm();
    for (int i = 0; i < 5; i++) tick();
    chk("s4_masked_armado", estado, 1);
    zona_pir[3] = 1'b0; tick(); tick();
    chk("s4_entrada", estado, 2);
    chk("s4_disparo", zona_disparo, 4'b1000);

    // 5: two wrong PINs -> ALARMA + lockout, keys ignored, then disarm
    press(4'd1); press(4'd2); press(4'd3); press(4'hB);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'hB);
    chk("s5_alarma", estado, 3);
    chk("s5_bloqueo", bloqueo, 1);
    hi = 1;
    press(4'd1); if (bloqueo) hi++;
    press(4'd2); if (bloqueo) hi++;
    press(4'd3); if (bloqueo) hi++;
    press(4'd4); if (bloqueo) hi++;
    press(4'hB); if (bloqueo) hi++;
    chk("s5_keys_ignored", estado, 3);
    guard = 0;
    while (bloqueo && guard < 100) begin tick(); if (bloqueo) hi++; guard++; end
    chk("s5_lock_len", hi, LC);
    type_pin();
    chk("s5_disarmed", estado, 0);
    idle_defaults();

    // 6a: disarm from ALARMA with a dropped 5th digit
    arm();
    zona_pir[1] = 1'b0;
    guard = 0;
    while (estado != 2'd3 && guard < 100) begin tick(); guard++; end
    chk("s6_reach_alarma", estado, 3);
    zona_pir = '1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'hB);
    chk("s6_fifth_dropped", estado, 0);
    // 6b: '*' clears a partial entry
    arm();
    press(4'd1); press(4'd2); press(4'hA); type_pin();
    chk("s6_star_clear", estado, 0);
    // 6c: correct '#' on the timeout cycle
    arm();
    zona_pir[2] = 1'b0; tick(); tick();
    chk("s6_entrada", estado, 2);
    zona_pir = '1;
    for (int i = 0; i < 5; i++) tick();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("s6_before_hash", estado, 2);
    press(4'hB);
    chk("s6_timeout_disarm", estado, 0);
    chk("s6_timeout_alerta", alerta_pin, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      for (int z = 0; z < NZ; z++) zona_pir[z] = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 49) == 0) zona_mask = NZ'($urandom);
      armar = ($urandom_range(0, 7) == 0);
      if (pend.size() == 0 && $urandom_range(0, 29) == 0) begin
        pend.push_back(4'd1); pend.push_back(4'd2); pend.push_back(4'd3);
        pend.push_back(4'd4); pend.push_back(4'hB);
      end
      if (pend.size() != 0) begin
        key_valid = 1'b1; key_code = pend.pop_front();
      end else begin
        key_valid = ($urandom_range(0, 3) == 0);
        key_code = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alarma_multizona.md
# alarma_multizona

Parametrised multi-zone intrusion controller. Monitors `NUM_ZONAS` active-low PIR inputs with per-zone masking. Accepts a multi-digit PIN from a strobed keypad decoder, runs an entry-delay timer, and drives the alert and pulsed-siren outputs. Adds a failed-attempt lockout and exposes its state for the top-level status LEDs.

## Interface
- `NUM_ZONAS`, 4: number of PIR zones (1–16).
- `PIN_DIGITS`, 4: PIN length in BCD digits (1–8).
- `ENTRY_CYCLES`, 50000: entry delay, in clocks, before the alarm fires.
- `SIREN_HALF`, 25000: siren half-period in clocks (≥1).
- `MAX_FALLOS`, 3: wrong PINs that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 100000: keypad lockout duration in clocks.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `zona_pir`  in  NUM_ZONAS  PIR per zone; 0 = motion.
- `zona_mask`  in  NUM_ZONAS  1 = zone enabled.
- `armar`  in  1  arm request; level sampled each cycle.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid.
- `key_code`  in  4  0–9 digit, 0xA clear (`*`), 0xB enter (`#`); other codes ignored.
- `clave_correcta`  in  4*PIN_DIGITS  PIN as BCD, first digit in MS nibble.
- `alerta_pin`  out  1  1 while in ALARMA.
- `bocina_pin`  out  1  siren square wave in ALARMA, else 0.
- `armado`  out  1  1 in ARMADO, ENTRADA or ALARMA.
- `bloqueo`  out  1  keypad lockout active.
- `zona_disparo`  out  NUM_ZONAS  latched zones that caused or joined the event.
- `estado`  out  2  0 DESARMADO, 1 ARMADO, 2 ENTRADA, 3 ALARMA.

## Operation
- **Reset** (`reset`=0 at an edge): every output is 0, state is DESARMADO, and all counters, the digit buffer and the fail count clear. This applies from any state, including mid-alarm.
- **DESARMADO**
  - `armar`=1 → ARMADO.
  - On that transition, clear `zona_disparo` and the fail count.
  - Keypad input is ignored.
- **ARMADO**
  - Trigger set: `~zona_pir & zona_mask`, registered.
  - Any trigger bit set → ENTRADA; OR the trigger bits into `zona_disparo`.
  - Masked zones never trigger.
- **ENTRADA**
  - Entry counter counts from 0.
  - When the counter reaches `ENTRY_CYCLES-1` → ALARMA.
  - Newly triggered zones keep OR-ing into `zona_disparo`.
- **ALARMA**
  - `alerta_pin`=1.
  - `bocina_pin` starts at 1 and inverts every `SIREN_HALF` cycles.
  - Zones keep accumulating into `zona_disparo`.
  - Only a correct PIN or reset exits ALARMA.
- **PIN entry** (ARMADO, ENTRADA and ALARMA, only while `bloqueo`=0)
  - Digit: shift into the buffer and increment the digit count. The count saturates at `PIN_DIGITS`; further digits are dropped.
  - `*`: clear the buffer and the count.
  - `#`: the PIN is correct iff count == `PIN_DIGITS` and buffer == `clave_correcta`. Buffer and count clear after every `#`.
  - Correct PIN: → DESARMADO, fail count = 0, `zona_disparo` held for inspection.
  - Wrong PIN: fail count +1. On reaching `MAX_FALLOS`:
    - fail count = 0;
    - `bloqueo`=1 for `LOCKOUT_CYCLES` cycles;
    - ARMADO or ENTRADA → ALARMA immediately.
- **Ignored input**: `armar` while armed; keys during `bloqueo`; keys in DESARMADO.

## Timing
- `key_valid` on `#` at edge N → state, `armado`, `alerta_pin` and `bocina_pin` update at edge N+1.
- Zone low at edge N → registered at N+1 → `estado`=ENTRADA at N+2.
- ENTRADA lasts exactly `ENTRY_CYCLES` cycles.
- ALARMA toggle: `bocina_pin` holds each level for exactly `SIREN_HALF` cycles.
- Lockout: `bloqueo` rises the edge after the failing `#` and stays high for exactly `LOCKOUT_CYCLES` cycles. It is independent of state and continues after disarm-by-reset only if reset is not applied.
- Simultaneous events:
  - Correct `#` in the same cycle as entry timeout → DESARMADO (disarm wins).
  - Correct `#` in the same cycle as a new zone trigger in ARMADO → DESARMADO.
  - Wrong `#` that reaches `MAX_FALLOS` in the same cycle as entry timeout → ALARMA with `bloqueo`.
- Counters: entry counter `$clog2(ENTRY_CYCLES)` bits, siren counter `$clog2(SIREN_HALF)` bits, lockout counter `$clog2(LOCKOUT_CYCLES+1)` bits.
  - No counter wraps; each stops or reloads at its terminal count.
  - The entry and siren counters clear on every state change.

## Test plan
All scenarios use PIN_DIGITS=4, `clave_correcta`=16'h1234, ENTRY_CYCLES=10, SIREN_HALF=4, MAX_FALLOS=2, LOCKOUT_CYCLES=20.

1. Reset for 3 cycles with every input toggling → all outputs 0 and `estado`=0. Assert reset in ALARMA → outputs 0 at the next edge.
2. Arm, drop `zona_pir[2]` → ENTRADA at +2 cycles; ALARMA 10 cycles later; `zona_disparo`=4'b0100; `bocina_pin` pattern 1111 0000 repeating.
3. Arm, trigger zone 0, key 1,2,3,4,`#` in ENTRADA → `estado`=0 one cycle after `#`; `alerta_pin` never 1; `zona_disparo`=4'b0001.
4. Set `zona_mask`=4'b1110 and hold `zona_pir[0]`=0 → stays in ARMADO. Then drop `zona_pir[3]` → ENTRADA with `zona_disparo`=4'b1000.
5. In ENTRADA, enter 1,2,3,`#` then 9,9,9,9,`#` → ALARMA after the second `#` with `bloqueo`=1 for 20 cycles. Keys during `bloqueo` have no effect. 1,2,3,4,`#` after `bloqueo` falls → DESARMADO.
6. In ALARMA, enter 1,2,3,4,5,`#` → disarms (5th digit dropped). Then in ARMADO, enter 1,2,`*`,1,2,3,4,`#` → DESARMADO. Correct `#` on the exact entry-timeout cycle → DESARMADO with `alerta_pin`=0.
